uart_frame_rx: RTL and testbench
================================

Name: uart_frame_rx

Overview:
- Receive-side deframer between a byte-level UART receiver and the external-data mux.
- Hunts for a sync byte, assembles a 4-byte payload (board ID + BCD score word, MSB first), and checks an XOR checksum.
- On a good frame, presents a held 32-bit word with a one-cycle valid strobe.
- Tracks link liveness and counts framing errors, so the score display can blank a dead opponent link.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- BYTE_TIMEOUT, 7500, max pclk cycles between consecutive bytes inside a frame.
- LINK_TIMEOUT, 75000000, pclk cycles without a good frame before link_alive drops.

Ports:
- pclk  input  1  system pixel clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- rx_data  input  8  received byte; valid only when rx_valid=1.
- rx_valid  input  1  one-cycle strobe per received byte.
- ext_data  output  32  last good payload, {b0,b1,b2,b3}; b0 = board ID.
- data_valid  output  1  one-cycle pulse when ext_data updates.
- frame_err  output  1  one-cycle pulse on checksum mismatch or inter-byte timeout.
- err_cnt  output  8  saturating count of frame_err events.
- link_alive  output  1  1 while a good frame arrived within the last LINK_TIMEOUT cycles.

Behaviour:
- Reset, sampled on pclk when rst_n=0: ext_data=0, data_valid=0, frame_err=0, err_cnt=0, link_alive=0, state=IDLE, byte index=0, checksum accumulator=0, both timers=0.
- States: IDLE, PAYLOAD, CHECK.
- IDLE:
  - rx_valid with rx_data==SYNC_BYTE -> PAYLOAD; clear index, accumulator and byte timer.
  - Any other byte is ignored with no error.
- PAYLOAD:
  - Each rx_valid shifts the byte into a 32-bit shift register (first byte lands in [31:24]).
  - Each byte is XORed into the accumulator and increments the index.
  - After the 4th byte -> CHECK.
  - A byte equal to SYNC_BYTE is treated as data; there is no resync.
- CHECK, on rx_valid:
  - If rx_data==accumulator: ext_data<=shift register, data_valid=1 next cycle, link timer cleared, link_alive=1 next cycle.
  - Otherwise: frame_err=1 next cycle, ext_data unchanged.
  - Either way -> IDLE.
- Latency: data_valid and frame_err rise exactly 1 cycle after the rx_valid strobe of the checksum byte.
- Byte timer:
  - Counts in PAYLOAD and CHECK; cleared on each rx_valid.
  - When it reaches BYTE_TIMEOUT with no rx_valid that cycle: frame_err pulse, -> IDLE, partial payload discarded.
  - rx_valid in the same cycle as timer expiry: the byte wins, timer cleared, no error.
- err_cnt: +1 per frame_err pulse; saturates at 255 and never wraps.
- Link timer:
  - Increments every cycle and saturates at LINK_TIMEOUT.
  - link_alive=0 once the timer equals LINK_TIMEOUT.
  - A good frame in the same cycle as saturation: the good frame wins, link_alive stays 1.
- rx_valid asserted on back-to-back cycles must be accepted every cycle (one byte per clock).
- rst_n low mid-frame: frame discarded, all state reset; no frame_err issued.
- Timer widths: $clog2(parameter+1).
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
1. Good frame: bytes A5,01,00,12,34,27 -> ext_data=32'h01001234, one data_valid pulse 1 cycle after 27, link_alive=1, err_cnt=0.
2. Bad checksum: A5,01,00,12,34,28 -> frame_err pulse, err_cnt=1, ext_data keeps its prior value (0 after reset), no data_valid.
3. Noise and sync-in-payload:
   - Stimulus: 00,FF,A5,02,A5,00,07,(02^A5^00^07=A0).
   - Required: 00/FF ignored with no error; ext_data=32'h02A50007, data_valid=1.
4. Byte timeout with BYTE_TIMEOUT=16:
   - Stimulus: A5,01, then 16 idle cycles, then 00,12,34,27.
   - Required: frame_err on timeout, err_cnt=1; trailing bytes ignored in IDLE; no data_valid.
5. Link timeout with LINK_TIMEOUT=100: good frame, then 100 idle cycles -> link_alive falls exactly when the timer reaches 100. A further good frame -> link_alive=1 again.
6. Reset and saturation:
   - rst_n=0 after A5,01 -> all outputs 0 and no frame_err; a subsequent full good frame is decoded correctly.
   - 300 bad frames -> err_cnt=255.

Source files
------------

// File: rtl/uart_frame_rx.sv
// Receive-side deframer: sync hunt, 4-byte payload, XOR check.
// Tracks link liveness and a saturating framing-error count.
module uart_frame_rx #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         BYTE_TIMEOUT = 7500,
  parameter int         LINK_TIMEOUT = 75000000
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] ext_data,
  output logic        data_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        link_alive
);

  localparam int BW = $clog2(BYTE_TIMEOUT + 1);
  localparam int LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [BW-1:0] BT_LAST = BW'(BYTE_TIMEOUT - 1);
  localparam logic [LW-1:0] LT_MAX  = LW'(LINK_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECK
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [7:0]    acc;
  logic [31:0]   sh;
  logic [BW-1:0] btmr;
  logic [LW-1:0] ltmr;

  logic [LW-1:0] ltmr_nxt;
  logic          b_exp;
  logic          good_ev;
  logic          err_ev;

  // Expiry is the idle cycle that would carry the timer up to BYTE_TIMEOUT.
  always_comb begin
    ltmr_nxt = (ltmr == LT_MAX) ? ltmr : ltmr + 1'b1;
    b_exp    = !rx_valid && (btmr == BT_LAST);
    good_ev  = (state == CHECK) && rx_valid && (rx_data == acc);
    err_ev   = ((state != IDLE) && b_exp) ||
               ((state == CHECK) && rx_valid && (rx_data != acc));
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      acc        <= '0;
      sh         <= '0;
      btmr       <= '0;
      ltmr       <= '0;
      ext_data   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      err_cnt    <= '0;
      link_alive <= 1'b0;
    end else begin
      data_valid <= good_ev;
      frame_err  <= err_ev;
      if (err_ev && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
      if (good_ev) begin
        ext_data   <= sh;
        ltmr       <= '0;
        link_alive <= 1'b1;
      end else begin
        ltmr <= ltmr_nxt;
        if (ltmr_nxt == LT_MAX)
          link_alive <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            state <= PAYLOAD;
            idx   <= '0;
            acc   <= '0;
            btmr  <= '0;
          end
        end
        PAYLOAD: begin
          if (rx_valid) begin
            sh   <= {sh[23:0], rx_data};
            acc  <= acc ^ rx_data;
            idx  <= idx + 2'd1;
            btmr <= '0;
            if (idx == 2'd3)
              state <= CHECK;
          end else if (b_exp) begin
            state <= IDLE;
          end else begin
            btmr <= btmr + 1'b1;
          end
        end
        CHECK: begin
          if (rx_valid || b_exp)
            state <= IDLE;
          else
            btmr <= btmr + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: frame table plus corner sequences,
// output pulses checked against a queue of expected events.
module tb_uart_frame_rx;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] ext_data;
  logic        data_valid;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        link_alive;

  uart_frame_rx #(
    .SYNC_BYTE(8'hA5),
    .BYTE_TIMEOUT(16),
    .LINK_TIMEOUT(100)
  ) dut (
    .pclk(pclk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .ext_data(ext_data),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .err_cnt(err_cnt),
    .link_alive(link_alive)
  );

  always #5 pclk = ~pclk;

  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    logic [63:0] bytes;
    bit          good;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    bit          good;
    logic [31:0] data;
    logic [7:0]  errc;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_good = '0;
  logic [7:0]  exp_err = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] b,
                              input bit g, input logic [31:0] d);
    vec_t v;
    v.n = n;
    v.bytes = b;
    v.good = g;
    v.data = d;
    return v;
  endfunction

  task automatic expect_ev(input bit good, input logic [31:0] d,
                           input int due);
    exp_t e;
    if (good) last_good = d;
    else if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
    e.good = good;
    e.data = last_good;
    e.errc = exp_err;
    e.due = due;
    q.push_back(e);
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge pclk);
    rx_valid = 1'b1;
    rx_data = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      rx_valid = 1'b0;
      rx_data = 8'h00;
    end
  endtask

  task automatic send_vec(input vec_t v);
    logic [63:0] b;
    b = v.bytes;
    for (int i = 0; i < v.n; i++) begin
      put(b[8*(v.n-1-i) +: 8]);
      if (i == v.n - 1) expect_ev(v.good, v.data, cyc + 1);
    end
  endtask

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge pclk) begin
    if (rst_n) begin
      if (data_valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, data_valid, frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind", {30'd0, data_valid, frame_err},
              e.good ? 32'd2 : 32'd1);
          chk("pulse_cycle", cyc, e.due);
          chk("ext_data", ext_data, e.data);
          chk("err_cnt", {24'd0, err_cnt}, {24'd0, e.errc});
          if (e.good) chk("link_alive_on_good", {31'd0, link_alive}, 32'd1);
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        chk("missing_pulse", cyc, q[0].due);
        void'(q.pop_front());
      end
    end
  end

  vec_t tbl[6];
  int   c0;

  initial begin
    tbl[0] = mk(6, 64'hA50100123427, 1'b1, 32'h01001234);
    tbl[1] = mk(6, 64'hA50100123428, 1'b0, 32'h0);
    tbl[2] = mk(8, 64'h00FFA502A50007A0, 1'b1, 32'h02A50007);
    tbl[3] = mk(6, 64'hA5DEADBEEF22, 1'b1, 32'hDEADBEEF);
    tbl[4] = mk(7, 64'h33A5FFFFFFFF00, 1'b1, 32'hFFFFFFFF);
    tbl[5] = mk(6, 64'hA5FFFFFFFFFF, 1'b0, 32'h0);

    repeat (3) @(negedge pclk);
    chk("rst_ext_data", ext_data, 32'd0);
    chk("rst_flags", {29'd0, data_valid, frame_err, link_alive}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      send_vec(tbl[i]);
      idle(3);
    end

    // Inter-byte timeout after sync + one byte; tail ignored in IDLE.
    put(8'hA5);
    put(8'h01);
    expect_ev(1'b0, 32'h0, cyc + 17);
    idle(16);
    put(8'h00);
    put(8'h12);
    put(8'h34);
    put(8'h27);
    idle(20);

    // Byte arriving on the expiry cycle wins.
    put(8'hA5);
    idle(15);
    send_vec(mk(5, 64'h0100123427, 1'b1, 32'h01001234));
    idle(3);

    // Link timeout edge, then recovery.
    send_vec(tbl[3]);
    c0 = cyc;
    idle(1);
    while (cyc < c0 + 100) @(negedge pclk);
    chk("link_alive_t99", {31'd0, link_alive}, 32'd1);
    @(negedge pclk);
    chk("link_alive_t100", {31'd0, link_alive}, 32'd0);
    idle(5);
    chk("link_dead_hold", {31'd0, link_alive}, 32'd0);
    send_vec(tbl[0]);
    idle(2);
    chk("link_recover", {31'd0, link_alive}, 32'd1);

    // Reset mid-frame.
    put(8'hA5);
    put(8'h01);
    @(negedge pclk);
    rx_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge pclk);
    chk("midrst_ext_data", ext_data, 32'd0);
    chk("midrst_flags", {29'd0, data_valid, frame_err, link_alive}, 32'd0);
    chk("midrst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    last_good = '0;
    exp_err = '0;
    idle(20);
    send_vec(tbl[2]);
    idle(3);

    // Saturation of the error counter.
    for (int i = 0; i < 300; i++) begin
      send_vec(tbl[1]);
      idle(1);
    end
    idle(3);
    chk("err_cnt_sat", {24'd0, err_cnt}, 32'd255);
    chk("ext_after_bad", ext_data, 32'h02A50007);

    idle(30);
    chk("queue_empty", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
